// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with a registered (Moore) match flag.
// The pattern length is fixed at build time. The pattern value and the overlap
// mode can change at run time. A saturating counter records the matches.
//
// Handshake: signal is consumed only in cycles where valid=1. There is no
// back-pressure; one bit can be accepted every cycle. load takes priority over
// valid, and a bit presented together with load is discarded.
module seq_detect_param #(
  parameter int unsigned              PAT_LEN  = 3,
  parameter logic [PAT_LEN-1:0]       PAT_INIT = 3'b101,
  parameter int unsigned              CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signal,
  input  logic               valid,
  input  logic               overlap,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pattern_in,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count
);

  // fill must represent 0..PAT_LEN inclusive
  localparam int unsigned FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] sr_q, sr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               detect_q, detect_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] sr_n;
  logic [FW-1:0]      fill_n;
  logic               hit;

  // Candidate history and fill level if the current bit were sampled
  always_comb begin
    sr_n   = {sr_q[PAT_LEN-2:0], signal};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    hit    = (sr_n == pat_q) && (fill_n == FILL_FULL);
  end

  // Next-state selection: load beats valid, valid beats idle
  always_comb begin
    pat_d    = pat_q;
    sr_d     = sr_q;
    fill_d   = fill_q;
    detect_d = 1'b0;
    cnt_d    = cnt_q;
    if (load) begin
      pat_d  = pattern_in;
      sr_d   = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (valid) begin
      sr_d     = sr_n;
      detect_d = hit;
      if (hit) begin
        // Non-overlapping mode discards the history credit so the next match
        // needs a full pattern's worth of fresh bits.
        fill_d = overlap ? fill_n : '0;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        fill_d = fill_n;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q    <= PAT_INIT;
      sr_q     <= '0;
      fill_q   <= '0;
      detect_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pat_q    <= pat_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      detect_q <= detect_d;
      cnt_q    <= cnt_d;
    end
  end

  assign detect      = detect_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Three builds are instantiated on shared
// stimulus: the default (3-bit, 8-bit count), a 4-bit pattern build, and a
// 2-bit pattern build with a 2-bit saturating counter.
module tb_seq_detect_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       signal, valid, overlap, load;
  logic [2:0] pat_a;
  logic [3:0] pat_b;
  logic [1:0] pat_c;
  logic       det_a, det_b, det_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  seq_detect_param #(.PAT_LEN(3), .PAT_INIT(3'b101), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .signal(signal), .valid(valid), .overlap(overlap),
    .load(load), .pattern_in(pat_a), .detect(det_a), .match_count(cnt_a));

  seq_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1101), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .signal(signal), .valid(valid), .overlap(overlap),
    .load(load), .pattern_in(pat_b), .detect(det_b), .match_count(cnt_b));

  seq_detect_param #(.PAT_LEN(2), .PAT_INIT(2'b11), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .signal(signal), .valid(valid), .overlap(overlap),
    .load(load), .pattern_in(pat_c), .detect(det_c), .match_count(cnt_c));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         dut;     // 0 = u_a, 1 = u_b, 2 = u_c
    logic       ld;
    logic [3:0] pat;
    logic       vld;
    logic       sig;
    logic       ovl;
    logic       exp_det;
    logic [7:0] exp_cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, input logic ld, input logic [3:0] p, input logic v,
                     input logic s, input logic o, input logic ed, input logic [7:0] ec,
                     input string n);
    vec_t t;
    t.dut = d; t.ld = ld; t.pat = p; t.vld = v; t.sig = s; t.ovl = o;
    t.exp_det = ed; t.exp_cnt = ec; t.name = n;
    vecs.push_back(t);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ld, input logic [3:0] p, input logic v,
                       input logic s, input logic o);
    @(negedge clk);
    load    = ld;
    pat_a   = p[2:0];
    pat_b   = p;
    pat_c   = p[1:0];
    valid   = v;
    signal  = s;
    overlap = o;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t);
    logic       d;
    logic [7:0] c;
    drive(t.ld, t.pat, t.vld, t.sig, t.ovl);
    case (t.dut)
      0:       begin d = det_a; c = cnt_a; end
      1:       begin d = det_b; c = cnt_b; end
      default: begin d = det_c; c = {6'b0, cnt_c}; end
    endcase
    check({t.name, ".detect"}, {31'b0, d}, {31'b0, t.exp_det});
    check({t.name, ".count"}, {24'b0, c}, {24'b0, t.exp_cnt});
  endtask

  // ---------------- test ----------------
  initial begin
    signal = 0; valid = 0; overlap = 1; load = 0;
    pat_a = '0; pat_b = '0; pat_c = '0;

    // overlap match: 101 on 1010101 -> hits after bits 3,5,7
    add(0,1,4'h5,0,0,1, 0,0,"ovl_load");
    add(0,0,4'h0,1,1,1, 0,0,"ovl_b1");
    add(0,0,4'h0,1,0,1, 0,0,"ovl_b2");
    add(0,0,4'h0,1,1,1, 1,1,"ovl_b3");
    add(0,0,4'h0,1,0,1, 0,1,"ovl_b4");
    add(0,0,4'h0,1,1,1, 1,2,"ovl_b5");
    add(0,0,4'h0,1,0,1, 0,2,"ovl_b6");
    add(0,0,4'h0,1,1,1, 1,3,"ovl_b7");
    add(0,0,4'h0,0,1,1, 0,3,"ovl_idle");
    // non-overlap: hits after bits 3 and 7 only
    add(0,1,4'h5,0,0,0, 0,0,"novl_load");
    add(0,0,4'h0,1,1,0, 0,0,"novl_b1");
    add(0,0,4'h0,1,0,0, 0,0,"novl_b2");
    add(0,0,4'h0,1,1,0, 1,1,"novl_b3");
    add(0,0,4'h0,1,0,0, 0,1,"novl_b4");
    add(0,0,4'h0,1,1,0, 0,1,"novl_b5");
    add(0,0,4'h0,1,0,0, 0,1,"novl_b6");
    add(0,0,4'h0,1,1,0, 1,2,"novl_b7");
    // valid gaps with signal toggling while valid=0
    add(0,1,4'h5,0,0,1, 0,0,"gap_load");
    add(0,0,4'h0,1,1,1, 0,0,"gap_v1");
    add(0,0,4'h0,0,0,1, 0,0,"gap_i1");
    add(0,0,4'h0,0,1,1, 0,0,"gap_i2");
    add(0,0,4'h0,1,0,1, 0,0,"gap_v2");
    add(0,0,4'h0,0,1,1, 0,0,"gap_i3");
    add(0,0,4'h0,0,0,1, 0,0,"gap_i4");
    add(0,0,4'h0,1,1,1, 1,1,"gap_v3");
    add(0,0,4'h0,0,0,1, 0,1,"gap_i5");
    // load together with valid: the bit is dropped
    add(0,1,4'h5,1,1,1, 0,0,"ldv_load");
    add(0,0,4'h0,1,0,1, 0,0,"ldv_b1");
    add(0,0,4'h0,1,1,1, 0,0,"ldv_b2");
    add(0,0,4'h0,1,0,1, 0,0,"ldv_b3");
    add(0,0,4'h0,1,1,1, 1,1,"ldv_b4");
    // 4-bit build: build up a count, then load 1101 mid-stream
    add(1,1,4'hF,0,0,1, 0,0,"rl_load1111");
    add(1,0,4'h0,1,1,1, 0,0,"rl_p1");
    add(1,0,4'h0,1,1,1, 0,0,"rl_p2");
    add(1,0,4'h0,1,1,1, 0,0,"rl_p3");
    add(1,0,4'h0,1,1,1, 1,1,"rl_p4");
    add(1,0,4'h0,1,1,1, 1,2,"rl_p5");
    add(1,1,4'hD,0,0,1, 0,0,"rl_load1101");
    add(1,0,4'h0,1,1,1, 0,0,"rl_b1");
    add(1,0,4'h0,1,1,1, 0,0,"rl_b2");
    add(1,0,4'h0,1,0,1, 0,0,"rl_b3");
    add(1,0,4'h0,1,1,1, 1,1,"rl_b4");
    add(1,0,4'h0,1,1,1, 0,1,"rl_b5");
    add(1,0,4'h0,1,0,1, 0,1,"rl_b6");
    add(1,0,4'h0,1,1,1, 1,2,"rl_b7");
    // 2-bit build, 2-bit counter: pattern 11, six 1s -> five hits, count sticks at 3
    add(2,1,4'h3,0,0,1, 0,0,"sat_load");
    add(2,0,4'h0,1,1,1, 0,0,"sat_b1");
    add(2,0,4'h0,1,1,1, 1,1,"sat_b2");
    add(2,0,4'h0,1,1,1, 1,2,"sat_b3");
    add(2,0,4'h0,1,1,1, 1,3,"sat_b4");
    add(2,0,4'h0,1,1,1, 1,3,"sat_b5");
    add(2,0,4'h0,1,1,1, 1,3,"sat_b6");
    add(2,0,4'h0,0,0,1, 0,3,"sat_idle");

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_det_a", {31'b0, det_a}, 32'd0);
    check("rst_cnt_a", {24'b0, cnt_a}, 32'd0);
    check("rst_cnt_c", {30'b0, cnt_c}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // reset mid-operation: detect high and count nonzero, then rst asserts
    drive(1, 4'h5, 0, 0, 1);
    drive(0, 4'h0, 1, 1, 1);
    drive(0, 4'h0, 1, 0, 1);
    drive(0, 4'h0, 1, 1, 1);
    check("pre_rst_det", {31'b0, det_a}, 32'd1);
    check("pre_rst_cnt", {24'b0, cnt_a}, 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_det", {31'b0, det_a}, 32'd0);
    check("async_rst_cnt", {24'b0, cnt_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // history 1,0 then a 1-cycle reset pulse then 1: no match may form
    drive(0, 4'h0, 1, 1, 1);
    drive(0, 4'h0, 1, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 4'h0, 1, 1, 1);
    check("post_rst_det", {31'b0, det_a}, 32'd0);
    check("post_rst_cnt", {24'b0, cnt_a}, 32'd0);
    drive(0, 4'h0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector with a Moore output, the next generation of the team's fixed 3-bit overlapping pattern detectors. Pattern length is set at build time; pattern value and overlap mode are set at run time. A saturating match counter is included. It sits on a qualified serial bit stream, for example after a synchroniser or deserialiser stage, and drives single-cycle detect pulses to downstream control logic.

## Interface
- PAT_LEN, 3: pattern length in bits; legal range 2..16.
- PAT_INIT, 3'b101 (PAT_LEN bits): pattern value loaded at reset.
- CNT_W, 8: match counter width; legal range 1..32.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- signal  in  1  serial data bit.
- valid  in  1  signal is sampled only in cycles where valid=1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- load  in  1  load pattern_in into the pattern register and restart detection.
- pattern_in  in  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received and bit 0 is the last.
- detect  out  1  Moore match flag, registered.
- match_count  out  CNT_W  number of detections since reset or the last load; saturates.

## Operation
- State registers:
  - pat: PAT_LEN bits, the active pattern.
  - sr: PAT_LEN-bit history; the newest bit is in the LSB.
  - fill: 0..PAT_LEN, the number of valid bits accumulated; saturates at PAT_LEN.
  - detect.
  - match_count.
- Reset (rst=0, asynchronous):
  - pat=PAT_INIT, sr=0, fill=0.
  - detect=0, match_count=0.
- Priority per cycle: load > valid > idle.
- Load cycle (load=1):
  - pat<=pattern_in, sr<=0, fill<=0, detect<=0, match_count<=0.
  - signal and valid are ignored in that cycle.
- Sample cycle (load=0, valid=1):
  - sr_n = {sr[PAT_LEN-2:0], signal}.
  - fill_n = min(fill+1, PAT_LEN).
  - hit = (sr_n==pat) && (fill_n==PAT_LEN).
  - sr<=sr_n and detect<=hit.
  - On hit with overlap=1: fill<=fill_n. The history is kept, so the tail of one match may start the next.
  - On hit with overlap=0: fill<=0. The next match needs PAT_LEN fresh bits.
  - No hit: fill<=fill_n.
  - On hit: match_count<=match_count+1. If it is already all ones, it holds.
- Idle cycle (load=0, valid=0):
  - sr, fill and match_count hold.
  - detect<=0. detect is never high for more than one cycle per hit.
- overlap is sampled on every hit cycle. A change takes effect at the next hit only; no restart occurs.
- A pattern with all bits equal, with overlap=1, yields a detect on every valid bit once fill saturates.
- Detection is Moore. detect is a registered function of state only, with no combinational path from signal to detect.

## Timing
- Latency: detect goes high in the cycle after the clock edge that samples the final pattern bit, and stays high for exactly one cycle.
- match_count updates on the same edge that sets detect.
- After reset or load, the earliest detect follows the PAT_LEN-th valid sample.
- rst deasserting mid-stream: all history is lost, and the previously received bits do not count toward a match.
- load and valid high together: the load wins and the bit is dropped.
- Throughput: one bit per cycle, with no stall.

## Test plan
- Overlap match:
  - Stimulus: PAT_LEN=3, pattern 101, overlap=1, valid=1, stream 1,0,1,0,1,0,1.
  - Required: detect pulses after bits 3, 5 and 7; match_count=3.
- Non-overlap match:
  - Stimulus: same stream with overlap=0.
  - Required: detect after bits 3 and 7 only; match_count=2.
- Valid gaps:
  - Stimulus: pattern 101, stream 1,0,1, with valid=0 for 2 cycles between each bit and signal toggling during the gaps.
  - Required: exactly one detect, in the cycle after the third valid bit.
- Runtime load:
  - Stimulus: PAT_LEN=4, load pattern 1101 mid-stream, then stream 1,1,0,1,1,0,1 with overlap=1.
  - Required: match_count cleared by the load; detects after bits 4 and 7; match_count=2.
- Counter saturation:
  - Stimulus: CNT_W=2, pattern 11, overlap=1, six consecutive 1s.
  - Required: five detects; match_count stops at 3.
- Reset mid-operation:
  - Stimulus: pattern 101; send 1,0; pulse rst low for 1 cycle; send 1.
  - Required: no detect; detect=0 and match_count=0 immediately on rst assertion.
